// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and helpers for the LED matrix scanner: default geometry,
// scan FSM states and the frame-to-row column extraction.
package led_matrix_pkg;

    localparam int LED_ROWS = 4;
    localparam int LED_COLS = 12;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Row r occupies frame bits r*COLS .. r*COLS+COLS-1; column j is bit r*COLS+j.
    function automatic logic [0:LED_COLS-1] row_slice(
        input logic [0:LED_ROWS*LED_COLS-1] frame,
        input int unsigned                  r
    );
        logic [0:LED_COLS-1] cols;
        for (int j = 0; j < LED_COLS; j++) begin
            cols[j] = frame[r*LED_COLS + j];
        end
        return cols;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame handshake and matrix drive signals between a frame producer and the scanner.
interface led_matrix_scanner_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS = LED_ROWS,
    parameter int COLS = LED_COLS
);
    logic [0:ROWS*COLS-1] frame_in;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [0:ROWS-1]      row_sel;
    logic [0:COLS-1]      col_out;
    logic                 frame_done;

    modport master (
        output frame_in, frame_valid,
        input  frame_ready, row_sel, col_out, frame_done
    );

    modport slave (
        input  frame_in, frame_valid,
        output frame_ready, row_sel, col_out, frame_done
    );
endinterface

// File: rtl/led_matrix_scanner_tick_div.sv
// Per-row dwell counter. Optional build macro LED_SCAN_BLANK_EN enables the
// blank window at the end of each dwell.
module scan_tick_div #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic blank_next
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK_ENABLED = 1'b1;
`else
    localparam bit BLANK_ENABLED = 1'b0;
`endif
    // With blanking off the window starts at DIV, which dwell never reaches.
    localparam int unsigned BLANK_START = BLANK_ENABLED ? int'(DIV - BLANK) : int'(DIV);

    logic [DW-1:0] dwell_q, dwell_d;

    always_comb begin
        tick       = en && (dwell_q == LAST);
        dwell_d    = (en && !tick) ? dwell_q + 1'b1 : '0;
        // Looks at the next dwell value so the registered outputs blank on time.
        blank_next = 32'(dwell_d) >= BLANK_START;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered multiplexed LED matrix row scanner; new frames swap in only at
// frame boundaries. Build macro LED_SCAN_BLANK_EN adds an anti-ghosting blank gap.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = LED_ROWS,
    parameter int COLS  = LED_COLS,
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_matrix_scanner_if.slave   bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    scan_state_t          state_q, state_d;
    logic                 pending_q, pending_d;
    logic [0:ROWS*COLS-1] shadow_q, shadow_d;
    logic [0:ROWS*COLS-1] active_q, active_d;
    logic [RW-1:0]        row_q, row_d;
    logic [0:ROWS-1]      row_sel_q, row_sel_d;
    logic [0:COLS-1]      col_out_q, col_out_d;
    logic                 frame_done_q, frame_done_d;

    logic tick;
    logic blank_next;

    scan_tick_div #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_tick_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q == SCAN),
        .tick       (tick),
        .blank_next (blank_next)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        row_d        = row_q;
        frame_done_d = 1'b0;

        // Accept only into a free shadow; swaps below only happen while it is full.
        if (bus.frame_valid && !pending_q) begin
            shadow_d  = bus.frame_in;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = SCAN;
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                    row_d     = '0;
                end
            end
            SCAN: begin
                if (tick) begin
                    row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                    if (row_q == LAST_ROW) begin
                        frame_done_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from next-state so they register in step with the row.
        row_sel_d = '0;
        col_out_d = '0;
        if (state_d == SCAN && !blank_next) begin
            row_sel_d[row_d] = 1'b1;
            col_out_d        = row_slice(active_d, 32'(row_d));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            row_q        <= '0;
            row_sel_q    <= '0;
            col_out_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            row_q        <= row_d;
            row_sel_q    <= row_sel_d;
            col_out_q    <= col_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.frame_ready = !pending_q;
    assign bus.row_sel     = row_sel_q;
    assign bus.col_out     = col_out_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised scoreboard bench for led_matrix_scanner: accepted frames are queued
// by the stimulus and a cycle-timeline reference model checks every output cycle.
module tb_led_matrix_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 12;
    localparam int DIV   = 3;
    localparam int BLANK = 1;
    localparam int FB    = ROWS * COLS;
`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scanner #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [0:FB-1] frame;
        int            acc;   // clock edge on which the frame is taken
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t, edge %0d)", name, act, exp, $time, cyc);
        end
    endtask

    function automatic logic [0:FB-1] pack_rows(input logic [COLS-1:0] rows [ROWS]);
        logic [0:FB-1] f;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = rows[r];
        return f;
    endfunction

    // Reference model: position in the scan is pure arithmetic on edges since scan start.
    bit            m_scanning = 1'b0;
    int            m_start    = 0;
    logic [0:FB-1] m_disp     = '0;

    initial begin
        forever begin
            logic [0:ROWS-1] e_sel;
            logic [0:COLS-1] e_col;
            logic            e_done;
            int              el, r, d;
            @(posedge clk);
            #1;
            e_sel  = '0;
            e_col  = '0;
            e_done = 1'b0;
            if (!rst_n) begin
                cyc        = 0;
                m_scanning = 1'b0;
                exp_q.delete();
            end else begin
                cyc++;
                if (!m_scanning) begin
                    if (exp_q.size() > 0 && exp_q[0].acc < cyc) begin
                        m_scanning = 1'b1;
                        m_start    = cyc;
                        m_disp     = exp_q.pop_front().frame;
                    end
                end else if (((cyc - m_start) % (ROWS*DIV)) == 0) begin
                    e_done = 1'b1;
                    if (exp_q.size() > 0 && exp_q[0].acc < cyc) m_disp = exp_q.pop_front().frame;
                end
                if (m_scanning) begin
                    el = cyc - m_start;
                    r  = (el / DIV) % ROWS;
                    d  = el % DIV;
                    if (!(BLANK_ON && d >= DIV - BLANK)) begin
                        e_sel[r] = 1'b1;
                        e_col    = m_disp[r*COLS +: COLS];
                    end
                end
            end
            check("row_sel",     64'(bus.row_sel),     64'(e_sel));
            check("col_out",     64'(bus.col_out),     64'(e_col));
            check("frame_done",  64'(bus.frame_done),  64'(e_done));
            check("frame_ready", 64'(bus.frame_ready), 64'(exp_q.size() == 0));
        end
    end

    task automatic send(input logic [0:FB-1] f, input string tag);
        int waited = 0;
        @(negedge clk);
        bus.frame_in    = f;
        bus.frame_valid = 1'b1;
        while (!bus.frame_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check({"accept_", tag}, 64'(bus.frame_ready), 64'd1);
        if (bus.frame_ready) begin
            exp_q.push_back('{f, cyc + 1});
            $display("frame %s %h accepted at edge %0d after %0d wait cycles", tag, f, cyc + 1, waited);
        end
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_row(input int r);
        logic [0:ROWS-1] want;
        int              n = 0;
        want    = '0;
        want[r] = 1'b1;
        while (bus.row_sel !== want && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_row", 64'(bus.row_sel), 64'(want));
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        rst_n           = 1'b0;
        #1;
        check("rst_row_sel",     64'(bus.row_sel),     64'd0);
        check("rst_col_out",     64'(bus.col_out),     64'd0);
        check("rst_frame_ready", 64'(bus.frame_ready), 64'd1);
        check("rst_frame_done",  64'(bus.frame_done),  64'd0);
        $display("reset pulse for %0d cycles at t=%0t", hold, $time);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [COLS-1:0] rows [ROWS];
        bus.frame_in    = '0;
        bus.frame_valid = 1'b0;
        pulse_reset(3);

        rows = '{12'h801, 12'h003, 12'h00F, 12'hFF0};
        send(pack_rows(rows), "first");
        repeat (20) @(negedge clk);

        wait_row(1);
        rows = '{12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA};
        send(pack_rows(rows), "aaa");
        rows = '{12'h555, 12'h555, 12'h555, 12'h555};
        send(pack_rows(rows), "555_held");
        repeat (30) @(negedge clk);

        wait_row(2);
        pulse_reset(1);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < ROWS; r++) rows[r] = COLS'($urandom);
            send(pack_rows(rows), "rand");
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 11)) @(negedge clk);
                pulse_reset($urandom_range(1, 3));
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
